// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types, default widths and slicing helper for regfile_mp.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    // LSB position of port `port` inside a packed multi-port vector.
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ============================================================================
// Module      : regfile_mp_if
// Description : Read/write/control bundle between the pipeline and regfile_mp.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       clr_req;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic                       ready;
    logic                       wr_drop;

    modport master (
        output clr_req, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_data, ready, wr_drop
    );

    modport slave (
        input  clr_req, rd_addr, wr_en, wr_addr, wr_data,
        output rd_data, ready, wr_drop
    );
endinterface

`default_nettype wire

// File: rtl/regfile_mp_rd_port.sv
// ============================================================================
// Module      : regfile_rd_port
// Description : One read port: ready gating, hardwired zero and write bypass.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_rd_port #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic              ready,
    input  wire logic [ADDR_W-1:0] rd_addr,
    input  wire logic              wr_en,
    input  wire logic [ADDR_W-1:0] wr_addr,
    input  wire logic [DATA_W-1:0] wr_data,
    input  wire logic [DATA_W-1:0] mem_rdata,
    output logic      [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = mem_rdata;
        if (!ready) begin
            rd_data = '0;
        end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) begin
            rd_data = wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module      : regfile_mp
// Description : Multi-read-port register file with sequenced clear engine.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    regfile_mp_if.slave bus
);

    localparam int              c_DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
    logic                ready_q, ready_d;
    logic                wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0]   mem_q [c_DEPTH];

    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_waddr;
    logic [DATA_W-1:0]   w_mem_wdata;
    logic                w_wr_zero;

    assign w_wr_zero = (ZERO_REG != 0) && (bus.wr_addr == '0);

    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        ready_d     = ready_q;
        wr_drop_d   = wr_drop_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = clr_cnt_q;
        w_mem_wdata = '0;

        if (rst) begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            ready_d   = 1'b0;
            wr_drop_d = 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    w_mem_we = 1'b1;
                    if (bus.wr_en) begin
                        wr_drop_d = 1'b1;
                    end
                    if (clr_cnt_q == c_LAST) begin
                        state_d = ST_READY;
                        ready_d = 1'b1;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
                ST_READY: begin
                    if (bus.clr_req) begin
                        // Accepting a clear resets the sticky flag, but a write
                        // colliding with the accept itself is still reported.
                        state_d   = ST_CLEAR;
                        clr_cnt_d = '0;
                        ready_d   = 1'b0;
                        wr_drop_d = bus.wr_en;
                    end else if (bus.wr_en && !w_wr_zero) begin
                        w_mem_we    = 1'b1;
                        w_mem_waddr = bus.wr_addr;
                        w_mem_wdata = bus.wr_data;
                    end
                end
                default: begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                    ready_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        state_q   <= state_d;
        clr_cnt_q <= clr_cnt_d;
        ready_q   <= ready_d;
        wr_drop_q <= wr_drop_d;
    end

    // Storage is deliberately reset-free; the sweep above zeroes it.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    logic [NUM_RD-1:0][DATA_W-1:0] w_rd_data;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] w_addr;
        assign w_addr = bus.rd_addr[port_lsb(k, ADDR_W) +: ADDR_W];

        regfile_rd_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_rd_port (
            .ready     (ready_q),
            .rd_addr   (w_addr),
            .wr_en     (bus.wr_en),
            .wr_addr   (bus.wr_addr),
            .wr_data   (bus.wr_data),
            .mem_rdata (mem_q[w_addr]),
            .rd_data   (w_rd_data[k])
        );
    end

    assign bus.rd_data = w_rd_data;
    assign bus.ready   = ready_q;
    assign bus.wr_drop = wr_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module      : tb_regfile_mp
// Description : Scoreboard bench driving a bypass and a non-bypass regfile_mp.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifc_b ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifc_n ();

    assign ifc_n.clr_req = ifc_b.clr_req;
    assign ifc_n.rd_addr = ifc_b.rd_addr;
    assign ifc_n.wr_en   = ifc_b.wr_en;
    assign ifc_n.wr_addr = ifc_b.wr_addr;
    assign ifc_n.wr_data = ifc_b.wr_data;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1))
        u_dut_byp (.clk(clk), .rst(rst), .bus(ifc_b.slave));

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0))
        u_dut_nob (.clk(clk), .rst(rst), .bus(ifc_n.slave));

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // sel: 0/1 = byp rd0/rd1, 2/3 = nob rd0/rd1, 4/5 = byp ready/wr_drop, 6/7 = nob
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                0: act = ifc_b.rd_data[31:0];
                1: act = ifc_b.rd_data[63:32];
                2: act = ifc_n.rd_data[31:0];
                3: act = ifc_n.rd_data[63:32];
                4: act = {31'd0, ifc_b.ready};
                5: act = {31'd0, ifc_b.wr_drop};
                6: act = {31'd0, ifc_n.ready};
                default: act = {31'd0, ifc_n.wr_drop};
            endcase
            n_cmp++;
            if (act !== e.exp) begin
                n_bad++;
                $display("FAIL %s sel=%0d: got %h expected %h (t=%0t)", e.name, e.sel, act, e.exp, $time);
            end
        end
    end

    task automatic push(input string nm, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic exp_rd(input string nm, input logic [31:0] b0, input logic [31:0] b1,
                          input logic [31:0] n0, input logic [31:0] n1);
        push(nm, 0, b0);
        push(nm, 1, b1);
        push(nm, 2, n0);
        push(nm, 3, n1);
    endtask

    task automatic exp_st(input string nm, input logic rdy, input logic drop);
        push(nm, 4, {31'd0, rdy});
        push(nm, 5, {31'd0, drop});
        push(nm, 6, {31'd0, rdy});
        push(nm, 7, {31'd0, drop});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] ra(input int p0, input int p1);
        logic [4:0] a0;
        logic [4:0] a1;
        a0 = 5'(p0);
        a1 = 5'(p1);
        return {a1, a0};
    endfunction

    task automatic wr(input bit en, input int addr, input logic [31:0] data);
        ifc_b.wr_en   = en;
        ifc_b.wr_addr = 5'(addr);
        ifc_b.wr_data = data;
    endtask

    initial begin : stim
        int spin;
        ifc_b.clr_req = 1'b0;
        ifc_b.rd_addr = ra(1, 2);
        wr(1'b0, 0, 32'h0);

        cyc(); exp_st("rst_hold", 1'b0, 1'b0); exp_rd("rst_rd", 0, 0, 0, 0);
        cyc(); exp_st("rst_hold", 1'b0, 1'b0); exp_rd("rst_rd", 0, 0, 0, 0);
        rst = 1'b0;
        exp_st("sweep0", 1'b0, 1'b0);
        for (int i = 1; i <= 32; i++) begin
            cyc();
            exp_st("sweep", i == 32, 1'b0);
            if (i < 32) exp_rd("sweep_rd", 0, 0, 0, 0);
        end

        cyc(); wr(1'b1, 5, 32'hDEADBEEF); ifc_b.rd_addr = ra(5, 6);
        exp_rd("wr5_same", 32'hDEADBEEF, 0, 0, 0);
        cyc(); wr(1'b0, 0, 0);
        exp_rd("rd5", 32'hDEADBEEF, 0, 32'hDEADBEEF, 0);

        cyc(); wr(1'b1, 0, 32'h12345678); ifc_b.rd_addr = ra(0, 0);
        exp_rd("zero_same", 0, 0, 0, 0);
        cyc(); wr(1'b0, 0, 0);
        exp_rd("zero_rd", 0, 0, 0, 0); exp_st("zero_st", 1'b1, 1'b0);

        cyc(); wr(1'b1, 7, 32'h11111111); ifc_b.rd_addr = ra(5, 5);
        exp_rd("dual_r5", 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        cyc(); wr(1'b1, 7, 32'hA5A5A5A5); ifc_b.rd_addr = ra(7, 7);
        exp_rd("bypass", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h11111111, 32'h11111111);
        cyc(); wr(1'b0, 0, 0);
        exp_rd("bypass_next", 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);

        for (int k = 1; k < 32; k++) begin
            cyc(); wr(1'b1, k, 32'(k)); ifc_b.rd_addr = ra(0, 0);
        end
        cyc(); wr(1'b0, 0, 0); ifc_b.rd_addr = ra(31, 1);
        exp_rd("fill", 31, 1, 31, 1);

        cyc(); ifc_b.clr_req = 1'b1; ifc_b.rd_addr = ra(3, 3);
        exp_rd("clr_accept_rd", 3, 3, 3, 3); exp_st("clr_accept", 1'b1, 1'b0);
        for (int i = 1; i <= 33; i++) begin
            cyc();
            ifc_b.clr_req = (i == 5);
            wr(i == 3, 3, 32'h333);
            ifc_b.rd_addr = ra(3, 31);
            exp_st("clr_sweep", i == 33, i >= 4);
            exp_rd("clr_rd", 0, 0, 0, 0);
        end
        for (int k = 0; k < 16; k++) begin
            cyc(); ifc_b.rd_addr = ra(k, k + 16);
            exp_rd("cleared", 0, 0, 0, 0);
        end
        exp_st("drop_sticky", 1'b1, 1'b1);

        cyc(); ifc_b.clr_req = 1'b1;
        exp_st("clr2_accept", 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            cyc();
            ifc_b.clr_req = 1'b0;
            wr(i == 1, 9, 32'h99);
            exp_st("clr2_sweep", 1'b0, i >= 2);
            if (i == 10) rst = 1'b1;
        end
        cyc(); rst = 1'b0;
        exp_st("rst_mid", 1'b0, 1'b0);
        for (int j = 1; j <= 32; j++) begin
            cyc();
            exp_st("rst_sweep", j == 32, 1'b0);
        end

        cyc(); wr(1'b1, 20, 32'hCAFEF00D); ifc_b.rd_addr = ra(20, 9);
        exp_rd("final_same", 32'hCAFEF00D, 0, 0, 0);
        cyc(); wr(1'b0, 0, 0);
        exp_rd("final_rd", 32'hCAFEF00D, 0, 32'hCAFEF00D, 0);

        spin = 0;
        while (sb.size() > 0 && spin < 10) begin
            cyc();
            spin++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time %0t reached, expected finish earlier", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire
